// File: rtl/gascon_pkg.sv
// Shared GASCON definitions: round constant, rotation tables, FSM state type.
// Rotation tables cover NW=5 (GASCON-320) and NW=9 (GASCON-576).
package gascon_pkg;

  localparam int ROUNDS_MAX = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gascon_state_e;

  localparam int unsigned ROT5_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT5_B [5] = '{28, 38, 6, 17, 40};
  localparam int unsigned ROT9_A [9] = '{19, 61, 1, 10, 7, 31, 53, 9, 43};
  localparam int unsigned ROT9_B [9] = '{28, 38, 6, 17, 40, 26, 58, 46, 50};

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic int unsigned rot_a(input int nw, input int w);
    return (nw == 5) ? ROT5_A[w % 5] : ROT9_A[w % 9];
  endfunction

  function automatic int unsigned rot_b(input int nw, input int w);
    return (nw == 5) ? ROT5_B[w % 5] : ROT9_B[w % 9];
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/gascon_perm_if.sv
// Job/result handshake bundle between the CryptoCore FSM (master) and the
// GASCON permutation core (slave).
interface gascon_perm_if #(
  parameter int NW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [64*NW-1:0]  state_in;
  logic [3:0]        rounds_in;
  logic              out_valid;
  logic              out_ready;
  logic [64*NW-1:0]  state_out;
  logic              busy;

  modport master (
    output in_valid, state_in, rounds_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, rounds_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/gascon_round.sv
// One combinational GASCON round: constant addition, NW-word chi-style
// S-box layer, per-word double-rotation linear layer.
module gascon_round
  import gascon_pkg::*;
#(
  parameter int NW = 5
) (
  input  logic [3:0]       idx,
  input  logic [64*NW-1:0] state_in,
  output logic [64*NW-1:0] state_out
);

  localparam int MID = NW / 2;

  logic [63:0] x_c [NW];
  logic [63:0] x_m [NW];
  logic [63:0] x_t [NW];
  logic [63:0] x_s [NW];

  // Every layer reads only the previous layer's array, so the word loops
  // are order independent and map directly onto parallel XOR/AND logic.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      x_c[w] = state_in[64*w +: 64];
    end
    x_c[MID] = x_c[MID] ^ {56'd0, rc(idx)};

    for (int w = 0; w < NW; w++) begin
      x_m[w] = (w % 2 == 0) ? (x_c[w] ^ x_c[(w + NW - 1) % NW]) : x_c[w];
    end

    for (int w = 0; w < NW; w++) begin
      x_t[w] = x_m[w] ^ (~x_m[(w + 1) % NW] & x_m[(w + 2) % NW]);
    end

    for (int w = 0; w < NW; w++) begin
      x_s[w] = (w % 2 == 1) ? (x_t[w] ^ x_t[(w + NW - 1) % NW]) : x_t[w];
    end
    x_s[MID] = ~x_s[MID];

    state_out = '0;
    for (int w = 0; w < NW; w++) begin
      state_out[64*w +: 64] = x_s[w]
                            ^ rotr64(x_s[w], rot_a(NW, w))
                            ^ rotr64(x_s[w], rot_b(NW, w));
    end
  end

endmodule

// File: rtl/gascon_perm_core.sv
// Iterative GASCON permutation core, UNROLL rounds per clock, valid/ready both sides.
// Build option GASCON_CLEAR_ON_READ_EN: zero the state register when the result is taken.
module gascon_perm_core
  import gascon_pkg::*;
#(
  parameter int NW     = 5,
  parameter int UNROLL = 1
) (
  input logic           clk,
  input logic           rst_n,
  gascon_perm_if.slave  bus
);

  localparam int W = 64 * NW;

  gascon_state_e  state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [W-1:0]   st_q, st_d;
  logic [W-1:0]   run_result;
  logic [3:0]     rounds_clamped;
  logic [5:0]     idx_sum;
  logic [3:0]     idx_adv;

  assign rounds_clamped = (bus.rounds_in > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : bus.rounds_in;
  assign idx_sum        = {2'b00, idx_q} + 6'(UNROLL);
  assign idx_adv        = (idx_sum >= 6'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : idx_sum[3:0];

  // Stages whose round index runs past the last round pass their input
  // straight through, so a short final step leaves the state untouched.
  for (genvar u = 0; u < UNROLL; u++) begin : g_stage
    logic [W-1:0] din;
    logic [W-1:0] rnd;
    logic [W-1:0] dout;
    logic [5:0]   ridx;

    assign ridx = {2'b00, idx_q} + 6'(u);

    if (u == 0) begin : g_first
      assign din = st_q;
    end else begin : g_next
      assign din = g_stage[u-1].dout;
    end

    gascon_round #(.NW(NW)) u_round (
      .idx       (ridx[3:0]),
      .state_in  (din),
      .state_out (rnd)
    );

    assign dout = (ridx < 6'(ROUNDS_MAX)) ? rnd : din;
  end

  assign run_result = g_stage[UNROLL-1].dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d    = bus.state_in;
          idx_d   = 4'(ROUNDS_MAX) - rounds_clamped;
          state_d = (rounds_clamped == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        st_d  = run_result;
        idx_d = idx_adv;
        if (idx_adv == 4'(ROUNDS_MAX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef GASCON_CLEAR_ON_READ_EN
          st_d    = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.state_out = st_q;

endmodule

// File: tb/tb_gascon_perm_core.sv
// Self-checking bench for gascon_perm_core: NW=5/UNROLL=1 and NW=9/UNROLL=4 instances
// against a word-level GASCON reference, plus hand-computed one-round vectors.
module tb_gascon_perm_core;

  logic clk;
  logic rst_n;

  gascon_perm_if #(.NW(5)) bus5 ();
  gascon_perm_if #(.NW(9)) bus9 ();

  gascon_perm_core #(.NW(5), .UNROLL(1)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  gascon_perm_core #(.NW(9), .UNROLL(4)) dut9 (.clk(clk), .rst_n(rst_n), .bus(bus9));

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int RA [9] = '{19, 61, 1, 10, 7, 31, 53, 9, 43};
  localparam int RB [9] = '{28, 38, 6, 17, 40, 26, 58, 46, 50};

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: last r rounds of 12, applied word by word.
  function automatic logic [575:0] gascon_ref(input logic [575:0] s, input int nw, input int r);
    logic [63:0]  x [9];
    logic [63:0]  t [9];
    logic [575:0] res;
    int           rr;
    rr = (r > 12) ? 12 : r;
    for (int w = 0; w < 9; w++) x[w] = s[64*w +: 64];
    for (int i = 12 - rr; i < 12; i++) begin
      x[nw/2] = x[nw/2] ^ {56'd0, 4'(15 - i), 4'(i)};
      for (int w = 0; w < nw; w += 2) x[w] = x[w] ^ x[(w + nw - 1) % nw];
      for (int w = 0; w < nw; w++) t[w] = ~x[w] & x[(w + 1) % nw];
      for (int w = 0; w < nw; w++) x[w] = x[w] ^ t[(w + 1) % nw];
      for (int w = 1; w < nw; w += 2) x[w] = x[w] ^ x[w - 1];
      x[nw/2] = ~x[nw/2];
      for (int w = 0; w < nw; w++) x[w] = x[w] ^ ror(x[w], RA[w]) ^ ror(x[w], RB[w]);
    end
    res = '0;
    for (int w = 0; w < nw; w++) res[64*w +: 64] = x[w];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Job-level expectation per instance: phase 0 idle, 1 computing, 2 result held.
  int           m5_ph = 0, m5_left = 0, m5_r = 0;
  int           m9_ph = 0, m9_left = 0, m9_r = 0;
  logic [575:0] m5_res = '0, m5_out = '0;
  logic [575:0] m9_res = '0, m9_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m5_ph = 0; m5_left = 0; m5_out = '0;
    end else if (m5_ph == 0) begin
      if (bus5.in_valid) begin
        m5_r    = (bus5.rounds_in > 4'd12) ? 12 : int'(bus5.rounds_in);
        m5_res  = gascon_ref(576'(bus5.state_in), 5, m5_r);
        m5_left = m5_r;
        m5_out  = 576'(bus5.state_in);
        m5_ph   = (m5_left == 0) ? 2 : 1;
      end
    end else if (m5_ph == 1) begin
      m5_left--;
      if (m5_left == 0) begin m5_ph = 2; m5_out = m5_res; end
    end else if (bus5.out_ready) begin
      m5_ph = 0;
`ifdef GASCON_CLEAR_ON_READ_EN
      m5_out = '0;
`endif
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m9_ph = 0; m9_left = 0; m9_out = '0;
    end else if (m9_ph == 0) begin
      if (bus9.in_valid) begin
        m9_r    = (bus9.rounds_in > 4'd12) ? 12 : int'(bus9.rounds_in);
        m9_res  = gascon_ref(bus9.state_in, 9, m9_r);
        m9_left = (m9_r + 3) / 4;
        m9_out  = bus9.state_in;
        m9_ph   = (m9_left == 0) ? 2 : 1;
      end
    end else if (m9_ph == 1) begin
      m9_left--;
      if (m9_left == 0) begin m9_ph = 2; m9_out = m9_res; end
    end else if (bus9.out_ready) begin
      m9_ph = 0;
`ifdef GASCON_CLEAR_ON_READ_EN
      m9_out = '0;
`endif
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready5",  576'(bus5.in_ready),  576'(m5_ph == 0));
    checkOutput("busy5",      576'(bus5.busy),      576'(m5_ph == 1));
    checkOutput("out_valid5", 576'(bus5.out_valid), 576'(m5_ph == 2));
    if (m5_ph != 1) checkOutput("state_out5", 576'(bus5.state_out), m5_out);
    checkOutput("in_ready9",  576'(bus9.in_ready),  576'(m9_ph == 0));
    checkOutput("busy9",      576'(bus9.busy),      576'(m9_ph == 1));
    checkOutput("out_valid9", 576'(bus9.out_valid), 576'(m9_ph == 2));
    if (m9_ph != 1) checkOutput("state_out9", bus9.state_out, m9_out);
  end

  function automatic logic outValid(input int sel);
    return (sel == 5) ? bus5.out_valid : bus9.out_valid;
  endfunction

  function automatic logic [575:0] stateOut(input int sel);
    return (sel == 5) ? 576'(bus5.state_out) : bus9.state_out;
  endfunction

  // Called #1 after a rising edge with the target instance idle.
  task automatic applyStimulus(input int sel, input logic [575:0] st, input logic [3:0] r);
    if (sel == 5) begin
      bus5.state_in = st[319:0]; bus5.rounds_in = r; bus5.in_valid = 1'b1;
    end else begin
      bus9.state_in = st; bus9.rounds_in = r; bus9.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    bus9.in_valid = 1'b0;
  endtask

  task automatic waitResult(input int sel, input int exp_edges, input string name);
    int n = 0;
    while (!outValid(sel) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 576'(n), 576'(exp_edges));
  endtask

  task automatic releaseOut(input int sel);
    if (sel == 5) bus5.out_ready = 1'b1; else bus9.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    bus9.out_ready = 1'b0;
  endtask

  logic [575:0] s9, res, pat, held;

  initial begin
    rst_n = 1'b0;
    bus5.in_valid = 1'b0; bus5.state_in = '0; bus5.rounds_in = '0; bus5.out_ready = 1'b0;
    bus9.in_valid = 1'b0; bus9.state_in = '0; bus9.rounds_in = '0; bus9.out_ready = 1'b0;
    for (int w = 0; w < 9; w++) s9[64*w +: 64] = 64'(64'h9E3779B97F4A7C15 * (w + 1)) ^ 64'(w);
    pat = '0;
    for (int w = 0; w < 5; w++) pat[64*w +: 64] = 64'h0123456789ABCDEF;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  576'(bus5.in_ready),  576'(1));
    checkOutput("rst_out_valid", 576'(bus5.out_valid), 576'(0));
    checkOutput("rst_busy",      576'(bus5.busy),      576'(0));
    checkOutput("rst_state_out", stateOut(5), '0);
    checkOutput("rst_state9",    stateOut(9), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(5, '0, 4'd1);
    waitResult(5, 1, "lat5_r1");
    res = stateOut(5);
    checkOutput("kat1_w0", 576'(res[63:0]),    576'(64'h000964B00000004B));
    checkOutput("kat1_w1", 576'(res[127:64]),  576'(64'h000000012C000213));
    checkOutput("kat1_w3", 576'(res[255:192]), 576'(64'h12E580000000004B));
    checkOutput("kat1_w4", 576'(res[319:256]), 576'(64'h0));
    releaseOut(5);
    @(negedge clk);
`ifdef GASCON_CLEAR_ON_READ_EN
    checkOutput("idle_cleared5", stateOut(5), '0);
`else
    checkOutput("idle_hold5", stateOut(5), gascon_ref('0, 5, 1));
`endif
    @(posedge clk); #1;

    applyStimulus(5, '0, 4'd12);
    waitResult(5, 12, "lat5_r12");
    checkOutput("p12_zero5", stateOut(5), gascon_ref('0, 5, 12));
    releaseOut(5);

    applyStimulus(9, s9, 4'd11);
    waitResult(9, 3, "lat9_r11");
    checkOutput("p11_nw9", stateOut(9), gascon_ref(s9, 9, 11));
    releaseOut(9);

    applyStimulus(9, s9, 4'd15);
    waitResult(9, 3, "lat9_r15");
    checkOutput("r15_clamp9", stateOut(9), gascon_ref(s9, 9, 12));
    releaseOut(9);

    applyStimulus(9, s9, 4'd12);
    waitResult(9, 3, "lat9_r12");
    checkOutput("p12_nw9", stateOut(9), gascon_ref(s9, 9, 12));
    releaseOut(9);

    applyStimulus(5, pat, 4'd0);
    waitResult(5, 0, "lat5_r0");
    checkOutput("r0_identity5", stateOut(5), pat);
    releaseOut(5);

    applyStimulus(9, s9, 4'd0);
    waitResult(9, 0, "lat9_r0");
    checkOutput("r0_identity9", stateOut(9), s9);
    releaseOut(9);

    applyStimulus(9, s9, 4'd5);
    waitResult(9, 2, "lat9_r5");
    held = gascon_ref(s9, 9, 5);
    for (int i = 0; i < 20; i++) begin
      bus9.in_valid  = i[0];
      bus9.state_in  = ~s9;
      bus9.rounds_in = 4'd1;
      @(posedge clk); #1;
      checkOutput("bp_state9",    stateOut(9), held);
      checkOutput("bp_in_ready9", 576'(bus9.in_ready), 576'(0));
    end
    bus9.in_valid = 1'b0;
    releaseOut(9);
    checkOutput("in_ready_after9", 576'(bus9.in_ready), 576'(1));

    applyStimulus(5, s9, 4'd12);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrun_busy5", 576'(bus5.busy), 576'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready5",  576'(bus5.in_ready),  576'(1));
    checkOutput("abort_out_valid5", 576'(bus5.out_valid), 576'(0));
    checkOutput("abort_busy5",      576'(bus5.busy),      576'(0));
    checkOutput("abort_state5",     stateOut(5), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(5, pat, 4'd2);
    waitResult(5, 2, "lat5_r2");
    checkOutput("p2_pat5", stateOut(5), gascon_ref(pat, 5, 2));
    releaseOut(5);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
